// File: rtl/mem_port_arbiter.sv
// N-port front end sharing one single-ported memory: one-entry request buffer per port,
// fixed-priority or round-robin arbitration, one command outstanding at a time.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RR_MODE    = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               halt_i,
    input  logic [NUM_PORTS-1:0]               req_start_i,
    input  logic [NUM_PORTS-1:0]               req_write_i,
    output logic [NUM_PORTS-1:0]               req_ready_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    req_wdata_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  req_wmask_i,
    output logic [NUM_PORTS-1:0]               resp_valid_o,
    output logic [DATA_WIDTH-1:0]              resp_rdata_o,
    output logic                               mem_cmd_start_o,
    output logic                               mem_cmd_write_o,
    input  logic                               mem_cmd_ready_i,
    output logic [ADDR_WIDTH-1:0]              mem_addr_o,
    output logic [DATA_WIDTH-1:0]              mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]            mem_wmask_o,
    input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
    input  logic                               mem_rdata_valid_i
);

    localparam int unsigned MW = DATA_WIDTH / 8;
    localparam int unsigned IW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRead} state_e;

    state_e                 state_q;
    logic [IW-1:0]          grant_q;
    logic [IW-1:0]          rr_ptr_q;
    logic [NUM_PORTS-1:0]   resp_valid_q;
    logic [DATA_WIDTH-1:0]  resp_rdata_q;

    logic [NUM_PORTS-1:0]   valid_q;
    logic [NUM_PORTS-1:0]   write_q;
    logic [ADDR_WIDTH-1:0]  addr_q  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  wdata_q [NUM_PORTS];
    logic [MW-1:0]          wmask_q [NUM_PORTS];

    logic [NUM_PORTS-1:0]   slot_clr;
    logic                   win_found;
    logic [IW-1:0]          win_idx;
    int unsigned            rr_idx;

    assign req_ready_o  = ~valid_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;

    // A slot frees when its write is accepted or its read data returns.
    always_comb begin
        slot_clr = '0;
        if ((state_q == StIssue && mem_cmd_ready_i && write_q[grant_q]) ||
            (state_q == StWaitRead && mem_rdata_valid_i)) begin
            slot_clr[grant_q] = 1'b1;
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (RR_MODE != 0) begin
                rr_idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
            end else begin
                rr_idx = k - 1;
            end
            if (!win_found && valid_q[IW'(rr_idx)]) begin
                win_found = 1'b1;
                win_idx   = IW'(rr_idx);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            write_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                wmask_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req_start_i[i] && !valid_q[i]) begin
                    valid_q[i] <= 1'b1;
                    write_q[i] <= req_write_i[i];
                    addr_q[i]  <= req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_q[i] <= req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                    wmask_q[i] <= req_wmask_i[i*MW +: MW];
                end else if (slot_clr[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_ptr_q     <= IW'(NUM_PORTS - 1);
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= '0;
            case (state_q)
                StIdle: begin
                    if (!halt_i && win_found) begin
                        grant_q <= win_idx;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (mem_cmd_ready_i) begin
                        rr_ptr_q <= grant_q;
                        state_q  <= write_q[grant_q] ? StIdle : StWaitRead;
                    end
                end
                StWaitRead: begin
                    if (mem_rdata_valid_i) begin
                        resp_rdata_q <= mem_rdata_i;
                        resp_valid_q <= NUM_PORTS'(1) << grant_q;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_cmd_start_o = 1'b0;
        mem_cmd_write_o = 1'b0;
        mem_addr_o      = '1;
        mem_wdata_o     = '1;
        mem_wmask_o     = '1;
        if (state_q == StIssue) begin
            mem_cmd_start_o = mem_cmd_ready_i;
            mem_cmd_write_o = write_q[grant_q];
            mem_addr_o      = addr_q[grant_q];
            mem_wdata_o     = wdata_q[grant_q];
            mem_wmask_o     = wmask_q[grant_q];
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 2-port fixed-priority instance and a 3-port round-robin
// instance, each with a small memory model and command/response scoreboards.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } cmd_t;

    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] d;
    } resp_t;

    typedef struct {
        int          p;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Fixed-priority instance
    logic        f_halt = 1'b0;
    logic [1:0]  f_req_start = '0, f_req_write = '0, f_req_ready, f_resp_valid;
    logic [63:0] f_req_addr = '0, f_req_wdata = '0;
    logic [7:0]  f_req_wmask = '0;
    logic [31:0] f_resp_rdata;
    logic        f_mem_start, f_mem_write, f_mem_ready = 1'b1;
    logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata = '0;
    logic [3:0]  f_mem_wmask;
    logic        f_mem_rvalid = 1'b0;

    // Round-robin instance
    logic [2:0]  r_req_start = '0, r_req_ready, r_resp_valid;
    logic [2:0]  r_req_write = '0;
    logic [95:0] r_req_addr = '0, r_req_wdata = '0;
    logic [11:0] r_req_wmask = '0;
    logic [31:0] r_resp_rdata;
    logic        r_mem_start, r_mem_write;
    logic [31:0] r_mem_addr, r_mem_wdata, r_mem_rdata = '0;
    logic [3:0]  r_mem_wmask;
    logic        r_mem_rvalid = 1'b0;

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0)) dut (
        .clk_i(clk), .rst_i(rst), .halt_i(f_halt),
        .req_start_i(f_req_start), .req_write_i(f_req_write), .req_ready_o(f_req_ready),
        .req_addr_i(f_req_addr), .req_wdata_i(f_req_wdata), .req_wmask_i(f_req_wmask),
        .resp_valid_o(f_resp_valid), .resp_rdata_o(f_resp_rdata),
        .mem_cmd_start_o(f_mem_start), .mem_cmd_write_o(f_mem_write),
        .mem_cmd_ready_i(f_mem_ready), .mem_addr_o(f_mem_addr), .mem_wdata_o(f_mem_wdata),
        .mem_wmask_o(f_mem_wmask), .mem_rdata_i(f_mem_rdata),
        .mem_rdata_valid_i(f_mem_rvalid)
    );

    mem_port_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1)) dut_rr (
        .clk_i(clk), .rst_i(rst), .halt_i(1'b0),
        .req_start_i(r_req_start), .req_write_i(r_req_write), .req_ready_o(r_req_ready),
        .req_addr_i(r_req_addr), .req_wdata_i(r_req_wdata), .req_wmask_i(r_req_wmask),
        .resp_valid_o(r_resp_valid), .resp_rdata_o(r_resp_rdata),
        .mem_cmd_start_o(r_mem_start), .mem_cmd_write_o(r_mem_write),
        .mem_cmd_ready_i(1'b1), .mem_addr_o(r_mem_addr), .mem_wdata_o(r_mem_wdata),
        .mem_wmask_o(r_mem_wmask), .mem_rdata_i(r_mem_rdata),
        .mem_rdata_valid_i(r_mem_rvalid)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : ((a ^ 32'hA5A5_0F0F) + 32'h1111);
    endfunction

    function automatic logic [31:0] rr_addr(input int p);
        return 32'h1000 + 32'(p) * 32'd16;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    cmd_t  f_cmd_q[$];
    resp_t f_resp_q[$];
    int    r_port_q[$];
    logic  f_pend = 1'b0, f_busy = 1'b0, r_pend = 1'b0, r_busy = 1'b0;
    logic [31:0] f_paddr = '0, r_paddr = '0;
    int    f_ncmd = 0, f_cmd_cyc = -1, f_resp_cyc = -1, r_last_port = 0;

    // Fixed instance: memory model (read data one cycle after issue) plus scoreboard.
    always @(negedge clk) begin
        cmd_t  ec;
        resp_t er;
        f_mem_rvalid = 1'b0;
        if (f_pend) begin
            f_mem_rvalid = 1'b1;
            f_mem_rdata  = mem_f(f_paddr);
            f_pend       = 1'b0;
        end
        if (f_resp_valid != 2'b00) begin
            f_resp_cyc = cyc;
            f_busy     = 1'b0;
            if (f_resp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL f_unexpected_resp: actual=%0h required=none", f_resp_valid);
            end else begin
                er = f_resp_q.pop_front();
                chk("f_resp", {f_resp_valid, f_resp_rdata}, er);
            end
        end
        if (f_mem_start) begin
            f_ncmd++;
            f_cmd_cyc = cyc;
            chk("f_overlap", f_busy, 0);
            if (f_cmd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL f_unexpected_cmd: actual=%0h required=none", f_mem_addr);
            end else begin
                ec = f_cmd_q.pop_front();
                chk("f_cmd", {f_mem_write, f_mem_addr, f_mem_wdata, f_mem_wmask}, ec);
            end
            if (!f_mem_write) begin
                f_pend  = 1'b1;
                f_paddr = f_mem_addr;
                f_busy  = 1'b1;
            end
        end
    end

    // Round-robin instance: memory model plus grant-order and routing checks.
    always @(negedge clk) begin
        logic [34:0] rexp;
        r_mem_rvalid = 1'b0;
        if (r_pend) begin
            r_mem_rvalid = 1'b1;
            r_mem_rdata  = mem_f(r_paddr);
            r_pend       = 1'b0;
        end
        if (r_resp_valid != 3'b000) begin
            r_busy = 1'b0;
            rexp   = {3'b001 << r_last_port, mem_f(rr_addr(r_last_port))};
            chk("rr_resp", {r_resp_valid, r_resp_rdata}, rexp);
        end
        if (r_mem_start) begin
            chk("rr_overlap", r_busy, 0);
            r_last_port = int'((r_mem_addr - 32'h1000) >> 4);
            if (r_port_q.size() > 0) chk("rr_grant", r_last_port, r_port_q.pop_front());
            if (!r_mem_write) begin
                r_pend  = 1'b1;
                r_paddr = r_mem_addr;
                r_busy  = 1'b1;
            end
        end
    end

    task automatic f_send(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output int acc);
        int n = 0;
        while (!f_req_ready[p] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL f_send_ready: actual=0 required=1");
        end
        f_req_start[p]          = 1'b1;
        f_req_write[p]          = w;
        f_req_addr[p*32 +: 32]  = a;
        f_req_wdata[p*32 +: 32] = d;
        f_req_wmask[p*4 +: 4]   = m;
        @(posedge clk); #1;
        acc            = cyc;
        f_req_start[p] = 1'b0;
    endtask

    task automatic f_push(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m);
        f_cmd_q.push_back({w, a, d, m});
        if (!w) f_resp_q.push_back({2'b01 << p, mem_f(a)});
    endtask

    task automatic f_drain(input string name);
        int n = 0;
        while (n < 80 && !(f_cmd_q.size() == 0 && f_resp_q.size() == 0 &&
                           f_req_ready == 2'b11 && !f_busy)) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drain"}, n < 80, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[6];
        int acc, acc2, n0, h;

        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int acc, acc2, n0, h;

        vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,         4'hF};
        vecs[1] = '{1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'hF};
        vecs[2] = '{1, 1'b0, 32'h0000_0200, 32'h1111_2222, 4'h1};
        vecs[3] = '{0, 1'b1, 32'hFFFF_FFF0, 32'h0BAD_0BAD, 4'h8};
        vecs[4] = '{0, 1'b0, 32'h0000_03FC, 32'h0,         4'h0};
        vecs[5] = '{1, 1'b0, 32'h8000_0000, 32'h5555_AAAA, 4'h6};

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  f_req_ready, 2'b11);
        chk("rst_resp",   {f_resp_valid, f_resp_rdata}, 34'h0);
        chk("rst_cmd",    {f_mem_start, f_mem_write, f_mem_addr}, {2'b00, 32'hFFFF_FFFF});
        chk("rst_rr_rdy", r_req_ready, 3'b111);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single read with latency checks
        n0 = f_ncmd;
        f_push(0, 1'b0, 32'h100, 32'h0, 4'hF);
        f_send(0, 1'b0, 32'h100, 32'h0, 4'hF, acc);
        f_drain("t1");
        chk("t1_ncmd", f_ncmd - n0, 1);
        chk("t1_cmd_lat", f_cmd_cyc, acc + 1);
        chk("t1_resp_lat", f_resp_cyc, acc + 3);
        chk("t1_ready0", f_req_ready[0], 1'b1);

        for (int i = 0; i < 6; i++) begin
            f_push(vecs[i].p, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m);
            f_send(vecs[i].p, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m, acc);
            f_drain("vec");
        end

        // Both ports in the same cycle: port 0 first
        f_push(0, 1'b0, 32'h10, 32'h0, 4'hF);
        f_push(1, 1'b0, 32'h20, 32'h0, 4'hF);
        f_req_write = 2'b00;
        f_req_addr  = {32'h20, 32'h10};
        f_req_wdata = '0;
        f_req_wmask = 8'hFF;
        f_req_start = 2'b11;
        @(posedge clk); #1;
        f_req_start = 2'b00;
        f_drain("both");

        // Write stalled by mem_cmd_ready low for three cycles
        f_mem_ready = 1'b0;
        n0 = f_ncmd;
        f_push(1, 1'b1, 32'h40, 32'h1234_5678, 4'b0011);
        f_send(1, 1'b1, 32'h40, 32'h1234_5678, 4'b0011, acc);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wr_hold", {f_mem_start, f_mem_write, f_mem_addr, f_mem_wdata, f_mem_wmask},
                {2'b01, 32'h40, 32'h1234_5678, 4'b0011});
            @(posedge clk); #1;
        end
        f_mem_ready = 1'b1;
        f_drain("wr");
        chk("wr_ncmd", f_ncmd - n0, 1);
        chk("wr_ready1", f_req_ready[1], 1'b1);

        // halt during WAIT_READ: port 0 finishes, port 1 waits for halt to drop
        f_push(0, 1'b0, 32'h500, 32'h0, 4'hF);
        f_push(1, 1'b0, 32'h600, 32'h0, 4'hF);
        n0 = f_ncmd;
        f_send(0, 1'b0, 32'h500, 32'h0, 4'hF, acc);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("halt_p0_issued", f_ncmd - n0, 1);
        @(posedge clk); #1;
        f_halt = 1'b1;
        n0 = f_ncmd;
        f_send(1, 1'b0, 32'h600, 32'h0, 4'hF, acc2);
        repeat (8) @(posedge clk);
        #1;
        chk("halt_block", f_ncmd - n0, 0);
        chk("halt_p0_done", f_resp_q.size(), 1);
        h = cyc;
        f_halt = 1'b0;
        f_drain("halt");
        chk("halt_release_lat", f_cmd_cyc, h + 1);

        // Reset in WAIT_READ with port 1 also buffered
        f_cmd_q.push_back({1'b0, 32'h700, 32'h0, 4'hF});
        n0 = f_ncmd;
        f_send(0, 1'b0, 32'h700, 32'h0, 4'hF, acc);
        f_send(1, 1'b0, 32'h800, 32'h0, 4'hF, acc2);
        @(negedge clk); #1;
        chk("rst_mid_issued", f_ncmd - n0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", f_req_ready, 2'b11);
        chk("rst_mid_resp", {f_resp_valid, f_resp_rdata}, 34'h0);
        chk("rst_mid_cmd", {f_mem_start, f_mem_write, f_mem_addr}, {2'b00, 32'hFFFF_FFFF});
        #1;
        rst = 1'b0;
        f_busy = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_ready2", f_req_ready, 2'b11);
        chk("rst_mid_nocmd", f_ncmd - n0, 1);

        // Round-robin: all three ports keep requesting
        for (int p = 0; p < 3; p++) r_req_addr[p*32 +: 32] = rr_addr(p);
        for (int k = 0; k < 6; k++) r_port_q.push_back(k % 3);
        r_req_start = 3'b111;
        begin
            int n = 0;
            while (r_port_q.size() > 0 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        r_req_start = 3'b000;
        chk("rr_seq_done", r_port_q.size(), 0);
        repeat (40) @(posedge clk);
        #1;
        chk("rr_idle", {r_req_ready, r_busy}, 4'b1110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
